regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//   Multi-port GPR file with write-back scoreboard, successor to the 2R/1W regfile.
//   Parametrised read and write port counts, same-cycle write->read forwarding, and a busy bit per register.
//   Issue marks a destination busy; any write-back clears it. Issue logic stalls on rd_busy.
//   Sits between decode/issue (read ports, issue port) and the write-back stage(s) (write ports).
// PARAMETERS
//   W   32  data word width
//   RW  5   register address width; 2**RW registers; r0 hard-wired zero
//   NR  4   number of read ports (>=1)
//   NW  2   number of write ports (>=1)
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   rst_n      in   1      asynchronous active-low reset
//   rd_en      in   NR     per read port enable
//   rd_addr    in   NR*RW  read addresses, port i at [i*RW +: RW]
//   rd_data    out  NR*W   read data, port i at [i*W +: W], combinational
//   rd_busy    out  NR     port i source has an outstanding producer, combinational
//   wr_en      in   NW     per write port enable
//   wr_addr    in   NW*RW  write addresses
//   wr_data    in   NW*W   write data
//   iss_en     in   1      issue: mark iss_addr busy
//   iss_addr   in   RW     destination of the issuing instruction
//   flush      in   1      synchronous clear of all busy bits (pipeline flush)
//   busy_cnt   out  RW+1   registered count of busy registers
// BEHAVIOUR
//   Reset (rst_n=0, async): all regs <= 0, all busy bits <= 0, busy_cnt <= 0.
//     While rst_n=0: rd_data all 0, rd_busy all 0. Reset mid-operation drops pending writes/issues.
//   Write: at posedge, regs[wr_addr[j]] <= wr_data[j] for each wr_en[j] with wr_addr[j]!=0.
//     Same address on several enabled ports: highest port index j wins; others discarded.
//   Read port i, priority order:
//     rd_addr==0 -> 0; !rd_en -> 0;
//     else if any enabled write port hits rd_addr -> forward wr_data of highest such j;
//     else regs[rd_addr].
//   rd_busy[i] = rd_en & (addr!=0) & busy[addr] & ~(any enabled write to addr this cycle).
//   Busy update at posedge, in priority order:
//     flush=1 -> all busy <= 0 (iss_en ignored that cycle; writes still commit);
//     iss_en & iss_addr!=0 -> busy[iss_addr] <= 1, even if written same cycle (new producer);
//     else any enabled write to addr -> busy[addr] <= 0.
//     Issue to r0 ignored; busy[0] always 0.
//   Write-back to a non-busy register is legal: data commits, busy stays 0.
//   busy_cnt reflects busy bits after the same posedge (1-cycle latency from iss_en/wr_en/flush).
//     Range 0..2**RW-1, no wrap possible since r0 is never busy.
//   No read latency; write visible via regs the cycle after commit, via forwarding the same cycle.
// TESTING
//   1 Reset: rst_n=0 mid-burst with wr_en=2'b11 -> rd_data=0, busy_cnt=0. After release, read r5 -> 0.
//   2 Conflict: wr0 r3=0xAAAA_0000 and wr1 r3=0x5555_1111 same cycle.
//     -> same-cycle read r3 = 0x5555_1111; next cycle regs r3 = 0x5555_1111.
//   3 Forward: wr0 r7=0x1234_5678, read ports 0..3 all r7 same cycle -> all 0x1234_5678.
//     Read r0 while writing r0=0xFFFF_FFFF -> 0.
//   4 Scoreboard: iss r9 -> next cycle rd_busy=1, busy_cnt=1.
//     wr1 r9=0x42 -> rd_busy=0 same cycle, data=0x42; busy_cnt=0 after the edge.
//   5 Re-issue collision: r9 busy; iss r9 and wr r9=0x7 same cycle -> r9=0x7, busy stays 1, busy_cnt=1.
//   6 Flush: iss r1, r2, r3 on consecutive cycles (busy_cnt=3); flush with iss r4
//     -> busy_cnt=0, r4 not busy.

Source files
------------

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Brief    : Multi-port GPR file with a write-back scoreboard.
//            NR combinational read ports, NW write ports, same-cycle
//            write->read forwarding, and one busy bit per register.
//            Issue marks a destination busy and a write-back clears it.
//            r0 always reads as zero and is never busy.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
  parameter int W  = 32,  // data word width
  parameter int RW = 5,   // register address width
  parameter int NR = 4,   // read port count
  parameter int NW = 2    // write port count
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NR-1:0]     rd_en,
  input  logic [NR*RW-1:0]  rd_addr,
  output logic [NR*W-1:0]   rd_data,
  output logic [NR-1:0]     rd_busy,
  input  logic [NW-1:0]     wr_en,
  input  logic [NW*RW-1:0]  wr_addr,
  input  logic [NW*W-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [RW-1:0]     iss_addr,
  input  logic              flush,
  output logic [RW:0]       busy_cnt
);

  localparam int NREG = 2 ** RW;
  localparam int CW   = RW + 1;

  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   busy_cnt_q;
  logic [CW-1:0]   busy_cnt_d;
  logic [NREG-1:0] wr_hit;      // register targeted by any enabled write this cycle

  // Write commit: ports applied in ascending order so the highest index wins.
  always_comb begin
    regs_d = regs_q;
    wr_hit = '0;
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j]) begin
        wr_hit[wr_addr[j*RW +: RW]] = 1'b1;
        if (wr_addr[j*RW +: RW] != '0) begin
          regs_d[wr_addr[j*RW +: RW]] = wr_data[j*W +: W];
        end
      end
    end
  end

  // Scoreboard update: write-back clears, issue sets (a new producer beats a
  // same-cycle write-back of the old one), flush clears everything.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (iss_en && (iss_addr != '0)) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
    busy_cnt_d = '0;
    for (int k = 0; k < NREG; k++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[k]);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= regs_d[k];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports: r0 and disabled ports return zero; otherwise the newest write
  // this cycle is forwarded ahead of the stored value. Outputs are held at
  // zero while reset is asserted so forwarded write data cannot leak out.
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [RW-1:0] addr;
    logic [W-1:0]  fwd;
    logic          live;

    assign addr = rd_addr[i*RW +: RW];
    assign live = rst_n & rd_en[i] & (addr != '0);

    // Forwarding mux for this port.
    always_comb begin
      fwd = regs_q[addr];
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && (wr_addr[j*RW +: RW] == addr)) begin
          fwd = wr_data[j*W +: W];
        end
      end
    end

    assign rd_data[i*W +: W] = live ? fwd : '0;
    assign rd_busy[i]        = live & busy_q[addr] & ~wr_hit[addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_sb
// Brief    : Self-checking bench for regfile_mp_sb. A reference model of the
//            register contents and busy set is checked against the DUT on
//            every falling edge; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

  localparam int W    = 32;
  localparam int RW   = 5;
  localparam int NR   = 4;
  localparam int NW   = 2;
  localparam int NREG = 2 ** RW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     rd_en;
  logic [NR*RW-1:0]  rd_addr;
  logic [NR*W-1:0]   rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*RW-1:0]  wr_addr;
  logic [NW*W-1:0]   wr_data;
  logic              iss_en;
  logic [RW-1:0]     iss_addr;
  logic              flush;
  logic [RW:0]       busy_cnt;

  int tests = 0;
  int fails = 0;

  regfile_mp_sb #(.W(W), .RW(RW), .NR(NR), .NW(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0]    m_regs [NREG];
  logic [NREG-1:0] m_busy;

  function automatic logic [NREG-1:0] next_busy();
    logic [NREG-1:0] nb;
    nb = m_busy;
    if (flush) return '0;
    for (int j = 0; j < NW; j++)
      if (wr_en[j]) nb[int'(wr_addr[j*RW +: RW])] = 1'b0;
    if (iss_en && iss_addr != 0) nb[int'(iss_addr)] = 1'b1;
    nb[0] = 1'b0;
    return nb;
  endfunction

  // Does any enabled write port target register a this cycle?
  function automatic bit written(int a);
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && int'(wr_addr[j*RW +: RW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] exp_data(int i);
    int a;
    logic [W-1:0] v;
    a = int'(rd_addr[i*RW +: RW]);
    if (!rst_n || !rd_en[i] || a == 0) return '0;
    v = m_regs[a];
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && int'(wr_addr[j*RW +: RW]) == a) v = wr_data[j*W +: W];
    return v;
  endfunction

  function automatic logic exp_busy(int i);
    int a;
    a = int'(rd_addr[i*RW +: RW]);
    if (!rst_n || !rd_en[i] || a == 0) return 1'b0;
    return m_busy[a] && !written(a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) m_regs[k] <= '0;
      m_busy <= '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*RW +: RW] != 0)
          m_regs[int'(wr_addr[j*RW +: RW])] <= wr_data[j*W +: W];
      m_busy <= next_busy();
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Continuous model comparison on every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("model rd_data[%0d]", i), 64'(rd_data[i*W +: W]), 64'(exp_data(i)));
      chk($sformatf("model rd_busy[%0d]", i), 64'(rd_busy[i]), 64'(exp_busy(i)));
    end
    chk("model busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic rd(input int i, input int a);
    rd_en[i] = 1'b1; rd_addr[i*RW +: RW] = RW'(a);
  endtask

  task automatic wr(input int j, input int a, input logic [W-1:0] d);
    wr_en[j] = 1'b1; wr_addr[j*RW +: RW] = RW'(a); wr_data[j*W +: W] = d;
  endtask

  task automatic iss(input int a);
    iss_en = 1'b1; iss_addr = RW'(a);
  endtask

  // Commit the current cycle's inputs and return to idle shortly after.
  task automatic tick();
    @(posedge clk); #1; idle();
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: reset mid-burst drops pending writes and scoreboard state
    iss(12); tick();
    wr(0, 5, 32'h1111_0005); wr(1, 6, 32'h2222_0006); rd(0, 5); settle();
    chk("burst fwd r5", 64'(rd_data[31:0]), 64'h1111_0005);
    chk("pre-reset busy_cnt", 64'(busy_cnt), 64'd1);
    #2 rst_n = 1'b0; #1;
    chk("reset rd_data0", 64'(rd_data[31:0]), 64'd0);
    chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1; idle();
    rd(0, 5); rd(1, 6); #1;
    chk("post-reset r5", 64'(rd_data[31:0]), 64'd0);
    chk("post-reset r6", 64'(rd_data[63:32]), 64'd0);
    tick();

    // 2: write conflict, highest port wins
    wr(0, 3, 32'hAAAA_0000); wr(1, 3, 32'h5555_1111); rd(0, 3); settle();
    chk("conflict fwd r3", 64'(rd_data[31:0]), 64'h5555_1111);
    tick();
    rd(0, 3); settle();
    chk("conflict stored r3", 64'(rd_data[31:0]), 64'h5555_1111);
    tick();

    // 3: forwarding to all ports, r0 stays zero, disabled port reads zero
    wr(0, 7, 32'h1234_5678);
    for (int i = 0; i < NR; i++) rd(i, 7);
    settle();
    chk("fwd p0", 64'(rd_data[31:0]),   64'h1234_5678);
    chk("fwd p1", 64'(rd_data[63:32]),  64'h1234_5678);
    chk("fwd p2", 64'(rd_data[95:64]),  64'h1234_5678);
    chk("fwd p3", 64'(rd_data[127:96]), 64'h1234_5678);
    tick();
    wr(0, 0, 32'hFFFF_FFFF); rd(0, 0); rd(1, 7); rd_en[1] = 1'b0; settle();
    chk("r0 read while written", 64'(rd_data[31:0]), 64'd0);
    chk("disabled port", 64'(rd_data[63:32]), 64'd0);
    tick();
    wr(0, 31, 32'hDEAD_BEEF); wr(1, 30, 32'hCAFE_F00D); tick();
    rd(2, 31); rd(3, 30); settle();
    chk("r31 stored", 64'(rd_data[95:64]),  64'hDEAD_BEEF);
    chk("r30 stored", 64'(rd_data[127:96]), 64'hCAFE_F00D);
    tick();

    // 4: scoreboard set then cleared by write-back
    iss(9); tick();
    rd(0, 9); settle();
    chk("r9 busy", 64'(rd_busy[0]), 64'd1);
    chk("busy_cnt after iss", 64'(busy_cnt), 64'd1);
    tick();
    wr(1, 9, 32'h42); rd(0, 9); settle();
    chk("wb clears busy same cycle", 64'(rd_busy[0]), 64'd0);
    chk("wb forward r9", 64'(rd_data[31:0]), 64'h42);
    tick();
    chk("busy_cnt after wb", 64'(busy_cnt), 64'd0);

    // 5: re-issue colliding with write-back keeps the register busy
    iss(9); tick();
    iss(9); wr(0, 9, 32'h7); tick();
    rd(0, 9); settle();
    chk("reissue r9 data", 64'(rd_data[31:0]), 64'h7);
    chk("reissue r9 busy", 64'(rd_busy[0]), 64'd1);
    chk("reissue busy_cnt", 64'(busy_cnt), 64'd1);
    tick();
    wr(0, 9, 32'h8); tick();
    chk("r9 cleared", 64'(busy_cnt), 64'd0);
    iss(0); tick();
    chk("issue r0 ignored", 64'(busy_cnt), 64'd0);

    // 6: flush clears all, ignores concurrent issue, still commits writes
    iss(1); tick();
    iss(2); tick();
    iss(3); tick();
    settle();
    chk("three busy", 64'(busy_cnt), 64'd3);
    flush = 1'b1; iss(4); wr(0, 1, 32'h99); tick();
    rd(0, 4); rd(1, 1); settle();
    chk("flush busy_cnt", 64'(busy_cnt), 64'd0);
    chk("flush r4 not busy", 64'(rd_busy[0]), 64'd0);
    chk("flush write r1", 64'(rd_data[63:32]), 64'h99);
    tick();

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
